// File: rtl/adder_rr_arbiter_pkg.sv
// Shared definitions for the round-robin adder arbiter: data width, opcodes,
// FSM state encoding and the latched operand payload.
package adder_rr_arbiter_pkg;

    localparam int unsigned DW  = 16;
    localparam int unsigned OPW = 3;

    localparam logic [OPW-1:0] OP_ADD  = 3'b000;
    localparam logic [OPW-1:0] OP_ADDU = 3'b001;
    localparam logic [OPW-1:0] OP_SUB  = 3'b010;
    localparam logic [OPW-1:0] OP_SUBU = 3'b011;
    localparam logic [OPW-1:0] OP_INC  = 3'b100;
    localparam logic [OPW-1:0] OP_DEC  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Operands and controls presented to the shared adder.
    typedef struct packed {
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
        logic [OPW-1:0] op;
        logic           cout_en_n;
    } alu_req_t;

    // Opcodes 110 and 111 are undefined.
    function automatic logic op_illegal(input logic [OPW-1:0] op);
        return op[2:1] == 2'b11;
    endfunction

endpackage

// File: rtl/adder_rr_arbiter_if.sv
// Bus bundle of the adder arbiter: requester side, shared-adder side and
// response channel.
//   slave  : arbiter view (takes requests, drives adder inputs and response)
//   master : client/environment view
interface adder_rr_arbiter_if
    import adder_rr_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4
);
    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]     req;
    logic [NREQ*DW-1:0]  req_a;
    logic [NREQ*DW-1:0]  req_b;
    logic [NREQ*OPW-1:0] req_op;
    logic [NREQ-1:0]     req_cout_en_n;
    logic [NREQ-1:0]     gnt;

    logic [DW-1:0]       alu_a;
    logic [DW-1:0]       alu_b;
    logic [OPW-1:0]      alu_control;
    logic                alu_carryout_n;
    logic [DW-1:0]       alu_c;
    logic                alu_ovf;
    logic                alu_cout;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [DW-1:0]       rsp_c;
    logic                rsp_ovf;
    logic                rsp_cout;
    logic                rsp_illegal;

    modport slave (
        input  req, req_a, req_b, req_op, req_cout_en_n,
        output gnt,
        output alu_a, alu_b, alu_control, alu_carryout_n,
        input  alu_c, alu_ovf, alu_cout,
        output rsp_valid, rsp_id, rsp_c, rsp_ovf, rsp_cout, rsp_illegal,
        input  rsp_ready
    );

    modport master (
        output req, req_a, req_b, req_op, req_cout_en_n,
        input  gnt,
        input  alu_a, alu_b, alu_control, alu_carryout_n,
        output alu_c, alu_ovf, alu_cout,
        input  rsp_valid, rsp_id, rsp_c, rsp_ovf, rsp_cout, rsp_illegal,
        output rsp_ready
    );

endinterface

// File: rtl/adder_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request searching upward from
// last_i+1, wrapping modulo NREQ.
//   req_i  : request vector
//   last_i : index of the previous winner
//   gnt_o  : one-hot winner (zero when no request)
//   idx_o  : winner index
//   any_o  : at least one request present
module adder_rr_arbiter_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    always_comb begin
        int unsigned cand;
        logic        found;
        cand  = 0;
        found = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(last_i) + k) % NREQ;
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IDW'(cand);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Shares one external 16-bit adder among NREQ requesters. A round-robin
// winner's operands are registered onto the adder for one cycle, the result
// is captured and returned on a valid/ready response channel.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : adder_rr_arbiter_if.slave (requests/gnt, adder ports, response)
module adder_rr_arbiter
    import adder_rr_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    adder_rr_arbiter_if.slave      bus
);

    localparam int unsigned IDW = $clog2(NREQ);

    state_e         state_q;
    logic [IDW-1:0] last_q;
    logic [IDW-1:0] id_q;
    alu_req_t       alu_q;

    logic           rsp_valid_q;
    logic [IDW-1:0] rsp_id_q;
    logic [DW-1:0]  rsp_c_q;
    logic           rsp_ovf_q;
    logic           rsp_cout_q;
    logic           rsp_illegal_q;

    logic [NREQ-1:0] pick_gnt;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic            take_c;
    alu_req_t        sel_c;

    adder_rr_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i  (bus.req),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // Accept a request only when idle, or when the current response leaves
    // this cycle; never while reset is asserted.
    assign take_c = !rst && pick_any &&
                    ((state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready));

    // Winner's operand slice.
    always_comb begin
        sel_c.a         = bus.req_a[DW*32'(pick_idx) +: DW];
        sel_c.b         = bus.req_b[DW*32'(pick_idx) +: DW];
        sel_c.op        = bus.req_op[OPW*32'(pick_idx) +: OPW];
        sel_c.cout_en_n = bus.req_cout_en_n[pick_idx];
    end

    assign bus.gnt            = take_c ? pick_gnt : '0;
    assign bus.alu_a          = alu_q.a;
    assign bus.alu_b          = alu_q.b;
    assign bus.alu_control    = alu_q.op;
    assign bus.alu_carryout_n = alu_q.cout_en_n;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_id         = rsp_id_q;
    assign bus.rsp_c          = rsp_c_q;
    assign bus.rsp_ovf        = rsp_ovf_q;
    assign bus.rsp_cout       = rsp_cout_q;
    assign bus.rsp_illegal    = rsp_illegal_q;

    // Arbitration / execute / response FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_q        <= IDW'(NREQ - 1);
            id_q          <= '0;
            alu_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_c_q       <= '0;
            rsp_ovf_q     <= 1'b0;
            rsp_cout_q    <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (take_c) begin
                        alu_q   <= sel_c;
                        last_q  <= pick_idx;
                        id_q    <= pick_idx;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_c_q       <= bus.alu_c;
                    rsp_ovf_q     <= bus.alu_ovf;
                    rsp_cout_q    <= bus.alu_cout;
                    rsp_illegal_q <= op_illegal(alu_q.op);
                    rsp_id_q      <= id_q;
                    rsp_valid_q   <= 1'b1;
                    state_q       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        if (take_c) begin
                            alu_q   <= sel_c;
                            last_q  <= pick_idx;
                            id_q    <= pick_idx;
                            state_q <= EXEC;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter with a behavioural model of the shared
// adder attached to the alu_* ports.
module tb_adder_rr_arbiter;
    import adder_rr_arbiter_pkg::*;

    localparam int unsigned N = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    adder_rr_arbiter_if #(.NREQ(N)) bus ();

    adder_rr_arbiter #(.NREQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared adder model.
    always_comb begin
        logic [16:0] s;
        logic        ovf;
        s   = 17'd0;
        ovf = 1'b0;
        case (bus.alu_control)
            3'b000, 3'b001: begin
                s   = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                ovf = (bus.alu_control == 3'b000) && (bus.alu_a[15] == bus.alu_b[15])
                      && (s[15] != bus.alu_a[15]);
            end
            3'b010, 3'b011: begin
                s   = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 17'd1;
                ovf = (bus.alu_control == 3'b010) && (bus.alu_a[15] != bus.alu_b[15])
                      && (s[15] != bus.alu_a[15]);
            end
            3'b100: begin
                s   = {1'b0, bus.alu_a} + 17'd1;
                ovf = (bus.alu_a == 16'h7FFF);
            end
            3'b101: begin
                s   = {1'b0, bus.alu_a} + 17'h0FFFF;
                ovf = (bus.alu_a == 16'h8000);
            end
            default: begin
                s   = 17'd0;
                ovf = 1'b0;
            end
        endcase
        bus.alu_c    = s[15:0];
        bus.alu_ovf  = ovf;
        bus.alu_cout = s[16] & ~bus.alu_carryout_n;
    end

    typedef struct {
        int          idx;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic        cen_n;
        logic [15:0] exp_c;
        logic        exp_ovf;
        logic        exp_cout;
        logic        exp_ill;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] op, input logic cen_n);
        bus.req[idx]                 = 1'b1;
        bus.req_a[16*idx +: 16]      = a;
        bus.req_b[16*idx +: 16]      = b;
        bus.req_op[3*idx +: 3]       = op;
        bus.req_cout_en_n[idx]       = cen_n;
    endtask

    initial begin
        int          order [8];
        logic [3:0]  onehot;
        logic [15:0] exp_c;

        checks = 0;
        errors = 0;

        vecs[0] = '{0, 16'h7FFF, 16'h0001, 3'b000, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1, 16'h0003, 16'h0005, 3'b011, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{2, 16'h0005, 16'h0003, 3'b011, 1'b0, 16'h0002, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{3, 16'h1234, 16'h5678, 3'b111, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1, 16'h8000, 16'h8000, 3'b001, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{2, 16'h8000, 16'h8000, 3'b001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{0, 16'h00FF, 16'hAAAA, 3'b100, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{3, 16'h0000, 16'h0000, 3'b101, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{0, 16'h8000, 16'h0001, 3'b010, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[9] = '{1, 16'h4444, 16'h1111, 3'b110, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};

        rst               = 1'b1;
        bus.req           = '0;
        bus.req_a         = '0;
        bus.req_b         = '0;
        bus.req_op        = '0;
        bus.req_cout_en_n = '0;
        bus.rsp_ready     = 1'b0;

        // Reset values, and no grant while reset is held even with requests.
        tick();
        tick();
        bus.req = 4'b1111;
        #1;
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_rsp_c", 32'(bus.rsp_c), 32'h0);
        check("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
        check("rst_alu_a", 32'(bus.alu_a), 32'h0);
        check("rst_alu_control", 32'(bus.alu_control), 32'h0);
        bus.req = '0;
        tick();
        rst = 1'b0;
        tick();

        // Single-request vectors: grant at T, operands on adder at T+1,
        // response at T+2.
        for (int i = 0; i < 10; i++) begin
            bus.rsp_ready = 1'b0;
            set_req(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cen_n);
            onehot = 4'b0001 << vecs[i].idx;
            #1;
            check($sformatf("v%0d_gnt", i), 32'(bus.gnt), 32'(onehot));
            tick();
            bus.req = '0;
            #1;
            check($sformatf("v%0d_exec_gnt", i), 32'(bus.gnt), 32'h0);
            check($sformatf("v%0d_exec_valid", i), 32'(bus.rsp_valid), 32'h0);
            check($sformatf("v%0d_alu_a", i), 32'(bus.alu_a), 32'(vecs[i].a));
            check($sformatf("v%0d_alu_b", i), 32'(bus.alu_b), 32'(vecs[i].b));
            check($sformatf("v%0d_alu_ctl", i), 32'(bus.alu_control), 32'(vecs[i].op));
            check($sformatf("v%0d_alu_cn", i), 32'(bus.alu_carryout_n), 32'(vecs[i].cen_n));
            tick();
            #1;
            check($sformatf("v%0d_valid", i), 32'(bus.rsp_valid), 32'h1);
            check($sformatf("v%0d_id", i), 32'(bus.rsp_id), 32'(vecs[i].idx));
            check($sformatf("v%0d_c", i), 32'(bus.rsp_c), 32'(vecs[i].exp_c));
            check($sformatf("v%0d_ovf", i), 32'(bus.rsp_ovf), 32'(vecs[i].exp_ovf));
            check($sformatf("v%0d_cout", i), 32'(bus.rsp_cout), 32'(vecs[i].exp_cout));
            check($sformatf("v%0d_ill", i), 32'(bus.rsp_illegal), 32'(vecs[i].exp_ill));
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
            #1;
            check($sformatf("v%0d_drop", i), 32'(bus.rsp_valid), 32'h0);
        end

        // Round-robin fairness from reset; requester 2 drops out midway.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        order = '{0, 1, 2, 3, 0, 1, 3, 0};
        for (int i = 0; i < 4; i++)
            set_req(i, 16'(16'h1000 * (i + 1)), 16'h0001, 3'b000, 1'b0);
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            onehot = 4'b0001 << order[k];
            #1;
            check($sformatf("rr%0d_gnt", k), 32'(bus.gnt), 32'(onehot));
            if (k > 0) begin
                exp_c = 16'(16'h1000 * (order[k-1] + 1) + 1);
                check($sformatf("rr%0d_valid", k), 32'(bus.rsp_valid), 32'h1);
                check($sformatf("rr%0d_id", k), 32'(bus.rsp_id), 32'(order[k-1]));
                check($sformatf("rr%0d_c", k), 32'(bus.rsp_c), 32'(exp_c));
            end
            tick();
            if (k == 4) bus.req = 4'b1011;
            if (k == 7) bus.req = 4'b0000;
            #1;
            check($sformatf("rr%0d_exec_gnt", k), 32'(bus.gnt), 32'h0);
            tick();
        end
        #1;
        check("rr_last_valid", 32'(bus.rsp_valid), 32'h1);
        check("rr_last_id", 32'(bus.rsp_id), 32'h0);
        tick();
        #1;
        check("rr_idle_valid", 32'(bus.rsp_valid), 32'h0);
        bus.rsp_ready = 1'b0;

        // Backpressure: response held 5 cycles, pending request waits.
        set_req(0, 16'h0001, 16'h0002, 3'b000, 1'b0);
        #1;
        check("bp_gnt0", 32'(bus.gnt), 32'h1);
        tick();
        bus.req = '0;
        set_req(2, 16'h0010, 16'h0020, 3'b000, 1'b0);
        #1;
        check("bp_exec_gnt", 32'(bus.gnt), 32'h0);
        tick();
        for (int j = 0; j < 5; j++) begin
            #1;
            check($sformatf("bp%0d_valid", j), 32'(bus.rsp_valid), 32'h1);
            check($sformatf("bp%0d_c", j), 32'(bus.rsp_c), 32'h3);
            check($sformatf("bp%0d_id", j), 32'(bus.rsp_id), 32'h0);
            check($sformatf("bp%0d_gnt", j), 32'(bus.gnt), 32'h0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_release_gnt", 32'(bus.gnt), 32'h4);
        tick();
        bus.rsp_ready = 1'b0;
        bus.req = '0;
        #1;
        check("bp_exec_valid", 32'(bus.rsp_valid), 32'h0);
        tick();
        #1;
        check("bp2_valid", 32'(bus.rsp_valid), 32'h1);
        check("bp2_id", 32'(bus.rsp_id), 32'h2);
        check("bp2_c", 32'(bus.rsp_c), 32'h30);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // Reset during EXEC: response discarded, pointer back to NREQ-1.
        set_req(3, 16'h0100, 16'h0001, 3'b000, 1'b0);
        #1;
        check("rx_gnt3", 32'(bus.gnt), 32'h8);
        tick();
        rst = 1'b1;
        bus.req = '0;
        #1;
        check("rx_rst_gnt", 32'(bus.gnt), 32'h0);
        tick();
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            check($sformatf("rx%0d_valid", j), 32'(bus.rsp_valid), 32'h0);
            tick();
        end
        set_req(3, 16'h0300, 16'h0003, 3'b000, 1'b0);
        set_req(0, 16'h0001, 16'h0001, 3'b000, 1'b0);
        #1;
        check("rx_first_gnt", 32'(bus.gnt), 32'h1);
        tick();
        bus.req[0] = 1'b0;
        tick();
        #1;
        check("rx_rsp_id0", 32'(bus.rsp_id), 32'h0);
        check("rx_rsp_c0", 32'(bus.rsp_c), 32'h2);
        bus.rsp_ready = 1'b1;
        #1;
        check("rx_next_gnt", 32'(bus.gnt), 32'h8);
        tick();
        bus.req = '0;
        bus.rsp_ready = 1'b0;
        tick();
        #1;
        check("rx_rsp_id3", 32'(bus.rsp_id), 32'h3);
        check("rx_rsp_c3", 32'(bus.rsp_c), 32'h0303);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // Reset after a grant to requester 1: with 1 and 3 requesting,
        // a restored pointer picks 1 again.
        set_req(1, 16'h0007, 16'h0001, 3'b000, 1'b0);
        #1;
        check("rp_gnt1", 32'(bus.gnt), 32'h2);
        tick();
        rst = 1'b1;
        bus.req = '0;
        tick();
        rst = 1'b0;
        set_req(1, 16'h0007, 16'h0001, 3'b000, 1'b0);
        set_req(3, 16'h0009, 16'h0001, 3'b000, 1'b0);
        #1;
        check("rp_after_rst_gnt", 32'(bus.gnt), 32'h2);
        tick();
        bus.req = '0;
        tick();
        #1;
        check("rp_rsp_c", 32'(bus.rsp_c), 32'h8);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
- Shares one combinational 16-bit adder/subtractor unit among NREQ requesters using round-robin arbitration.
- Per transaction: latch the winner's operands and opcode into registers, drive the shared adder from those registers for one cycle, capture sum and flags, return them on a single response channel with valid/ready backpressure.
- Sits between execution-side clients (address generation, loop counters, ALU ops) and the shared adder instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), width of the requester id.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  request from each requester; held until granted.
- req_a  input  NREQ*16  operand A per requester, slice i = [16*i+15:16*i].
- req_b  input  NREQ*16  operand B per requester.
- req_op  input  NREQ*3  opcode per requester: 000 add, 001 addu, 010 sub, 011 subu, 100 inc, 101 dec.
- req_cout_en_n  input  NREQ  carry-out enable per requester, active-low.
- gnt  output  NREQ  one-hot, one-cycle pulse in the cycle request i is accepted.
- alu_a  output  16  registered operand A to the shared adder.
- alu_b  output  16  registered operand B to the shared adder.
- alu_control  output  3  registered opcode to the shared adder.
- alu_carryout_n  output  1  registered carry-out enable (low = enabled).
- alu_c  input  16  adder result.
- alu_ovf  input  1  adder overflow flag.
- alu_cout  input  1  adder carry-out flag.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  IDW  index of the requester this response belongs to.
- rsp_c  output  16  captured result.
- rsp_ovf  output  1  captured overflow.
- rsp_cout  output  1  captured carry-out.
- rsp_illegal  output  1  opcode was 110 or 111.

Behaviour:
- Reset values:
  - gnt = 0, rsp_valid = 0.
  - All rsp_* and alu_* registers = 0.
  - Round-robin pointer last = NREQ-1, so requester 0 has top priority first.
  - State = IDLE.
- States: IDLE, EXEC, RESP.
- IDLE:
  - If req != 0: winner = first set bit searching upward from last+1, wrapping modulo NREQ.
  - Same cycle: assert gnt[winner]; on the edge, latch the winner's a/b/op/cout_en_n into alu_* registers, set last = winner, store winner id, go to EXEC.
  - If req == 0: stay in IDLE.
- EXEC (exactly one cycle):
  - The adder sees the registered operands.
  - On the edge, capture alu_c/alu_ovf/alu_cout into rsp_c/rsp_ovf/rsp_cout.
  - Set rsp_illegal = (alu_control[2:1] == 2'b11) and rsp_valid = 1; go to RESP.
  - req is ignored; gnt = 0.
- RESP:
  - Hold every rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp_ready:
    - If req != 0: arbitrate as in IDLE in the same cycle (gnt pulse, latch operands, go to EXEC); rsp_valid drops on that edge.
    - Otherwise: clear rsp_valid and go to IDLE.
- Latency and throughput:
  - Grant cycle T gives rsp_valid at T+2.
  - Sustained throughput is one op per 2 cycles with rsp_ready tied high.
- gnt is only ever asserted in IDLE, or in RESP together with rsp_ready. Never more than one bit is set.
- A requester must hold req and its operands stable until it sees its gnt bit. Operands are sampled only in the grant cycle.
- Illegal opcodes are accepted and forwarded. The adder yields C = 0 with both flags 0; rsp_illegal = 1.
- Between ops, alu_* keep their last values; no requirement to clear them.
- Reset asserted mid-operation:
  - Any in-flight or pending response is discarded.
  - All state returns to reset values on the next edge.
  - No gnt is asserted during the reset cycle.
- Fairness: with all NREQ requests held continuously, each requester is granted exactly once in every NREQ consecutive grants.

Decomposition:
- Shared package holds:
  - Opcode localparams OP_ADD..OP_DEC (000..101).
  - State encoding IDLE/EXEC/RESP.
  - Data width constant DW = 16.
- One natural sub-module: rr_pick (combinational).
  - Inputs: req vector and last pointer.
  - Outputs: one-hot grant and winner index.
  - Reusable by other arbiters.
- The adder itself is instantiated outside this block, at the same level; this block only drives and samples its ports.

Test Plan:
- Single request: req = 0001, A = 16'h7FFF, B = 16'h0001, op = 000, cout_en_n = 0 -> gnt = 0001 at T; rsp_valid at T+2 with rsp_id = 0, rsp_c = 16'h8000, rsp_ovf = 1, rsp_cout = 0.
- Unsigned sub with borrow: A = 16'h0003, B = 16'h0005, op = 011 -> rsp_c = 16'hFFFE, rsp_ovf = 0, rsp_cout = 0. With A = 5, B = 3 -> rsp_c = 2, rsp_cout = 1.
- Round-robin fairness: req = 1111 held, rsp_ready = 1 -> grant order 0,1,2,3,0, one grant every 2 cycles; requester 2 dropping req skips it without stalling.
- Backpressure: rsp_ready = 0 for 5 cycles after rsp_valid -> rsp_* stable, no gnt; a pending req is granted in the cycle rsp_ready rises.
- Illegal opcode: op = 111, A = 16'h1234 -> rsp_c = 0, rsp_ovf = 0, rsp_cout = 0, rsp_illegal = 1. Carry gating: op = 001, A = B = 16'h8000, cout_en_n = 1 -> rsp_cout = 0.
- Reset in EXEC: assert rst for 1 cycle after gnt -> no rsp_valid afterwards; next req = 1000 & 0001 together grants requester 0 first.
